// File: rtl/alu_mul_seq_if.sv
// Handshake bundle for the sequential 16x16 multiplier: operand request side and product response side.
// The optional zero-operand bypass (ALU_MUL_ZERO_BYPASS_EN) does not change this interface.
interface alu_mul_seq_if;
  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;
  logic              busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier wrapped around a 16-bit ripple-carry adder.
// Build option ALU_MUL_ZERO_BYPASS_EN: a zero operand skips the iterations and returns 0 straight away.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);
  localparam int unsigned PROD_W = 2 * WIDTH;

  if (WIDTH != 16) begin : g_width_chk
    $error("alu_mul_seq: WIDTH must be 16 to match the adder");
  end
  if ((WIDTH >> CNT_W) != 0) begin : g_cnt_chk
    $error("alu_mul_seq: CNT_W too narrow to hold WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    r_mq;
  logic [WIDTH-1:0]    r_mcand;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_prod;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [WIDTH-1:0]    w_add_b;
  logic [WIDTH-1:0]    w_sum;
  logic                w_carry;
  logic                w_accept;
  logic                w_last;
  logic                w_zero;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MUL_ZERO_BYPASS_EN
  assign w_zero = (bus.in_a == '0) | (bus.in_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Ripple-carry adder: acc + (mq[0] ? mcand : 0), used combinationally every CALC cycle
  always_comb begin
    logic c;
    w_add_b = r_mq[0] ? r_mcand : '0;
    w_sum   = '0;
    c       = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_sum[i] = r_acc[i] ^ w_add_b[i] ^ c;
      c        = (r_acc[i] & w_add_b[i]) | (c & (r_acc[i] ^ w_add_b[i]));
    end
    w_carry = c;
  end

  // State register plus registered status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_CALC);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: {acc,mq} shifts right through the adder carry once per CALC cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mq    <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= bus.in_a;
            r_mq    <= bus.in_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            if (w_zero) r_prod <= '0;
          end
        end
        S_CALC: begin
          r_acc <= {w_carry, w_sum[WIDTH-1:1]};
          r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_prod <= {w_carry, w_sum, r_mq[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_prod  = r_prod;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq; expectations follow the build's ALU_MUL_ZERO_BYPASS_EN setting.
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  alu_mul_seq_if bus ();

  alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency/busy, optionally stall the consumer, then complete the handshake
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                       input int exp_busy, input int hold, input string tag);
    int          lat;
    int          busy_n;
    logic [31:0] exp_p;
    exp_p  = 32'(a) * 32'(b);
    lat    = 0;
    busy_n = 0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = 16'($urandom);
    bus.in_b     = 16'($urandom);
    while (!bus.out_valid && lat < 64) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
    chk({tag, "_prod"}, bus.out_prod, exp_p);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_prod"}, bus.out_prod, exp_p);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra [10];
    logic [15:0] rb [10];
    int          seen;
    int          n;
    int          acc_cyc;
    int          prev_acc;
    int          zlat;
    int          zbusy;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset and idle state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_prod", bus.out_prod, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Basic products, including the carry-heavy maximum and a single-bit shift
    do_op(16'd3, 16'd5, 17, 16, 0, "mul_3x5");
    do_op(16'hFFFF, 16'hFFFF, 17, 16, 0, "mul_max");
    do_op(16'h8000, 16'h0002, 17, 16, 0, "mul_8000x2");
    do_op(16'h1234, 16'h00FF, 17, 16, 5, "mul_stall");

    // Reset during CALC iteration 7 aborts the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd100;
    bus.in_b     = 16'd200;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_out_prod", bus.out_prod, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
    do_op(16'd7, 16'd9, 17, 16, 0, "mul_7x9");

    // Zero operands
`ifdef ALU_MUL_ZERO_BYPASS_EN
    zlat  = 1;
    zbusy = 0;
`else
    zlat  = 17;
    zbusy = 16;
`endif
    do_op(16'h0000, 16'h1234, zlat, zbusy, 0, "mul_0xa");
    do_op(16'hBEEF, 16'h0000, zlat, zbusy, 0, "mul_ax0");

    // Back-to-back random pairs with in_valid and out_ready held high
    for (int k = 0; k < 10; k++) begin
      ra[k] = 16'($urandom_range(1, 65535));
      rb[k] = 16'($urandom_range(1, 65535));
    end
    prev_acc = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = ra[0];
    bus.in_b      = rb[0];
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!bus.in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_ready_wait", 32'(bus.in_ready), 32'd1);
      acc_cyc = cyc;
      if (k > 0) chk("b2b_interval", 32'(acc_cyc - prev_acc), 32'd18);
      prev_acc = acc_cyc;
      @(negedge clk);
      if (k < 9) begin
        bus.in_a = ra[k + 1];
        bus.in_b = rb[k + 1];
      end else begin
        bus.in_valid = 1'b0;
      end
      n = 0;
      while (!bus.out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_prod", bus.out_prod, 32'(ra[k]) * 32'(rb[k]));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_final_idle", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
